slice_job_scheduler: RTL and testbench
======================================

// Module: slice_job_scheduler
// PURPOSE
//  Shares one slice_unit between NUM_REQ requesters. Each requester submits a slice job (start, end) over a
//  64-element vector. A round-robin arbiter picks one job, which is split into consecutive 16-wide windows.
//  Each window is issued to the slice_unit as one command; the next is issued after the window completes.
//  When the whole job finishes, one response is returned to the granted requester.
// PARAMETERS
//  NUM_REQ   4   number of requesters (2..8)
//  ID_W      2   requester id width, clog2(NUM_REQ)
//  WIN       16  slice window width in elements (matches slice_unit output)
//  TMO_CYC   255 completion-wait limit in cycles (used only with SLICE_TIMEOUT_EN)
// PORTS
//  clk            in   1           clock
//  rst_n          in   1           reset, asynchronous, active-low
//  req_valid      in   NUM_REQ     per-requester job valid
//  req_ready      out  NUM_REQ     per-requester job accept (one-hot or zero)
//  req_start      in   NUM_REQ*6   packed job start index; requester r uses bits [6r+5:6r]
//  req_end        in   NUM_REQ*6   packed job end index (inclusive)
//  cmd_valid      out  1           window command to slice_unit valid_in
//  cmd_ready      in   1           slice_unit ready_in
//  cmd_start_idx  out  6           window start index
//  cmd_end_idx    out  6           window end index (inclusive)
//  cmd_last       out  1           current window is the last window of the job
//  win_done       in   1           1-cycle pulse: slice_unit output accepted (valid_out & ready_out)
//  rsp_valid      out  1           job response valid
//  rsp_ready      in   1           job response accept
//  rsp_id         out  ID_W        requester id of the completed job
//  rsp_err        out  1           job rejected (end < start) or timed out
//  rsp_windows    out  3           number of windows issued for the job (0..4)
//  busy           out  1           high in every state except IDLE
// BEHAVIOUR
//  Reset: all outputs 0 (req_ready, cmd_*, rsp_*, busy); state IDLE; rr pointer 0; internal counters 0.
//  FSM: IDLE -> ARB -> (CHECK) -> ISSUE -> WAIT -> ISSUE... -> RESP -> IDLE.
//  IDLE: if any req_valid, go to ARB. Otherwise stay.
//  ARB (1 cycle): grant the first valid requester at or after rr_ptr (wrapping). Drive req_ready[g]=1 for
//   exactly this cycle. Latch start/end/id. Set rr_ptr <= g+1 mod NUM_REQ. If no request is valid, return to IDLE.
//  CHECK (1 cycle): if end < start, set err=1, windows=0 and go to RESP; no command is issued. Otherwise
//   cur <= start and go to ISSUE.
//  ISSUE: cmd_valid=1; cmd_start_idx=cur; cmd_end_idx=min(cur+WIN-1, end).
//   All sums use 7-bit arithmetic, so cur+15 never wraps past 63.
//   cmd_last=(cur+WIN-1 >= end). Command fields stay stable while cmd_valid is high. On cmd_valid&cmd_ready,
//   windows++ and go to WAIT; cmd_valid drops in the next cycle.
//  WAIT: on win_done, if last go to RESP; else cur <= cur+WIN and go to ISSUE.
//   A win_done seen in any other state is ignored.
//  RESP: rsp_valid=1 holding id/err/windows until rsp_ready; on handshake go to IDLE. rsp_valid deasserts
//   the cycle after the handshake.
//  Latency: ARB->first cmd_valid = 2 cycles. Back-to-back windows: win_done -> next cmd_valid in 1 cycle.
//  Boundaries: start==end gives 1 window. start=0,end=63 gives 4 windows (0-15,16-31,32-47,48-63).
//   start=50,end=63 gives 1 window. Job inputs can change after the grant; latched copies are used.
//  A requester dropping req_valid before the grant is never granted. Only one job is in flight (no overlap).
//  Async reset mid-job: FSM returns to IDLE and the job is lost. Requesters re-submit.
// CONFIGURATION
//  SLICE_TIMEOUT_EN defined: a counter runs in WAIT and resets on entry to WAIT. If it reaches TMO_CYC
//   without win_done, the job is aborted: err=1, go to RESP, windows = windows issued so far.
//  SLICE_TIMEOUT_EN undefined: no counter. WAIT waits for win_done indefinitely. TMO_CYC is unused.
// TESTING
//  1 single job r0 start=0 end=63, cmd_ready=1, win_done 3 cycles after each cmd
//    -> 4 cmds (0/15,16/31,32/47,48/63), last on 4th; rsp id=0 err=0 windows=4
//  2 r0..r3 all valid continuously, each job start=5 end=5
//    -> grants in order 0,1,2,3,0; each rsp windows=1, cmd 5/5 cmd_last=1
//  3 r2 start=40 end=10
//    -> no cmd_valid; rsp id=2 err=1 windows=0 two cycles after grant
//  4 start=50 end=63 with cmd_ready held low 5 cycles
//    -> cmd_valid and cmd 50/63 stable for 6 cycles; rsp windows=1
//  5 rsp_ready low 4 cycles while other requests are pending
//    -> rsp fields held, no new req_ready until rsp handshake completes
//  6 rst_n low in WAIT of a 4-window job
//    -> all outputs 0 immediately, rr_ptr=0; with SLICE_TIMEOUT_EN, no win_done for TMO_CYC gives err=1

Source files
------------

// File: rtl/slice_job_if.sv
// Job/command/response bundle between requesters, slice_job_scheduler and the slice_unit.
// master: requesters plus slice_unit side; slave: the scheduler.
interface slice_job_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ*6-1:0] req_start;
  logic [NUM_REQ*6-1:0] req_end;

  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [5:0]           cmd_start_idx;
  logic [5:0]           cmd_end_idx;
  logic                 cmd_last;
  logic                 win_done;

  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [ID_W-1:0]      rsp_id;
  logic                 rsp_err;
  logic [2:0]           rsp_windows;

  modport master (
    output req_valid, req_start, req_end, cmd_ready, win_done, rsp_ready,
    input  req_ready, cmd_valid, cmd_start_idx, cmd_end_idx, cmd_last,
           rsp_valid, rsp_id, rsp_err, rsp_windows
  );

  modport slave (
    input  req_valid, req_start, req_end, cmd_ready, win_done, rsp_ready,
    output req_ready, cmd_valid, cmd_start_idx, cmd_end_idx, cmd_last,
           rsp_valid, rsp_id, rsp_err, rsp_windows
  );
endinterface

// File: rtl/slice_job_scheduler.sv
// Round-robin scheduler splitting slice jobs into WIN-wide windows for a shared slice_unit.
// Optional SLICE_TIMEOUT_EN: abort a job whose window completion takes TMO_CYC cycles.
module slice_job_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int WIN     = 16
`ifdef SLICE_TIMEOUT_EN
  , parameter int TMO_CYC = 255
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  slice_job_if.slave bus,
  output logic       busy
);

  typedef enum logic [2:0] {IDLE, ARB, CHECK, ISSUE, WAIT, RESP} state_t;

  state_t          state_q, state_d;
  logic [ID_W-1:0] rr_ptr_q;
  logic [ID_W-1:0] grant;
  logic [ID_W:0]   arb_idx;
  logic            any_valid;
  logic [5:0]      sel_start, sel_end;
  logic [5:0]      start_q, end_q, cur_q;
  logic [ID_W-1:0] id_q;
  logic [2:0]      win_cnt_q;
  logic            err_q, last_q;
  logic [6:0]      win_end7;
  logic            win_is_last;
  logic [5:0]      win_end;

`ifdef SLICE_TIMEOUT_EN
  localparam int TMO_W = $clog2(TMO_CYC + 1);
  logic [TMO_W-1:0] tmo_cnt_q;
  logic             tmo_hit;

  always_comb tmo_hit = (tmo_cnt_q == TMO_W'(TMO_CYC - 1));
`endif

  // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ
  always_comb begin
    any_valid = 1'b0;
    grant     = '0;
    arb_idx   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      arb_idx = {1'b0, rr_ptr_q} + (ID_W+1)'(i);
      if (arb_idx >= (ID_W+1)'(NUM_REQ))
        arb_idx = arb_idx - (ID_W+1)'(NUM_REQ);
      if (!any_valid && bus.req_valid[arb_idx[ID_W-1:0]]) begin
        any_valid = 1'b1;
        grant     = arb_idx[ID_W-1:0];
      end
    end
  end

  always_comb begin
    sel_start = '0;
    sel_end   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant == ID_W'(i)) begin
        sel_start = bus.req_start[6*i +: 6];
        sel_end   = bus.req_end[6*i +: 6];
      end
    end
  end

  // 7-bit sum so cur+WIN-1 never wraps below end
  always_comb begin
    win_end7    = {1'b0, cur_q} + 7'(WIN - 1);
    win_is_last = (win_end7 >= {1'b0, end_q});
    win_end     = win_is_last ? end_q : win_end7[5:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (|bus.req_valid) state_d = ARB;
      ARB:   state_d = any_valid ? CHECK : IDLE;
      CHECK: state_d = (end_q < start_q) ? RESP : ISSUE;
      ISSUE: if (bus.cmd_ready) state_d = WAIT;
      WAIT: begin
        if (bus.win_done) state_d = last_q ? RESP : ISSUE;
`ifdef SLICE_TIMEOUT_EN
        else if (tmo_hit) state_d = RESP;
`endif
      end
      RESP:  if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q  <= '0;
      start_q   <= '0;
      end_q     <= '0;
      cur_q     <= '0;
      id_q      <= '0;
      win_cnt_q <= '0;
      err_q     <= 1'b0;
      last_q    <= 1'b0;
`ifdef SLICE_TIMEOUT_EN
      tmo_cnt_q <= '0;
`endif
    end else begin
      case (state_q)
        ARB: begin
          if (any_valid) begin
            start_q  <= sel_start;
            end_q    <= sel_end;
            id_q     <= grant;
            rr_ptr_q <= (grant == ID_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
          end
        end
        CHECK: begin
          win_cnt_q <= '0;
          err_q     <= (end_q < start_q);
          cur_q     <= start_q;
        end
        ISSUE: begin
          if (bus.cmd_ready) begin
            win_cnt_q <= win_cnt_q + 3'd1;
            last_q    <= win_is_last;
`ifdef SLICE_TIMEOUT_EN
            tmo_cnt_q <= '0;
`endif
          end
        end
        WAIT: begin
          if (bus.win_done) begin
            if (!last_q) cur_q <= cur_q + 6'(WIN);
          end
`ifdef SLICE_TIMEOUT_EN
          else if (tmo_hit) err_q <= 1'b1;
          else tmo_cnt_q <= tmo_cnt_q + 1'b1;
`endif
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.req_ready     = '0;
    bus.cmd_valid     = 1'b0;
    bus.cmd_start_idx = '0;
    bus.cmd_end_idx   = '0;
    bus.cmd_last      = 1'b0;
    bus.rsp_valid     = 1'b0;
    bus.rsp_id        = '0;
    bus.rsp_err       = 1'b0;
    bus.rsp_windows   = '0;
    busy              = (state_q != IDLE);
    case (state_q)
      ARB: if (any_valid) bus.req_ready[grant] = 1'b1;
      ISSUE: begin
        bus.cmd_valid     = 1'b1;
        bus.cmd_start_idx = cur_q;
        bus.cmd_end_idx   = win_end;
        bus.cmd_last      = win_is_last;
      end
      RESP: begin
        bus.rsp_valid   = 1'b1;
        bus.rsp_id      = id_q;
        bus.rsp_err     = err_q;
        bus.rsp_windows = win_cnt_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_slice_job_scheduler.sv
// Directed self-checking bench for slice_job_scheduler.
module tb_slice_job_scheduler;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int WIN     = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;

  always #5 clk = ~clk;

  slice_job_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

  slice_job_scheduler #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .WIN(WIN)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus),
    .busy (busy)
  );

  int tests_run = 0;
  int tests_failed = 0;

  // responder configuration
  int done_dly, cmd_low, rsp_low;
  bit oneshot;

  // observations
  int         grant_id_q[$], grant_cyc_q[$];
  logic [5:0] cmd_s_q[$], cmd_e_q[$];
  logic       cmd_l_q[$];
  int         cmd_cyc_q[$];
  int         rsp_id_q[$], rsp_err_q[$], rsp_win_q[$], rsp_cyc_q[$];
  int         cmd_valid_cyc, cmd_unstable, rsp_valid_cyc, rsp_unstable;

  task automatic do_reset();
    rst_n = 1'b0;
    bus.req_valid = '0;
    bus.req_start = '0;
    bus.req_end   = '0;
    bus.cmd_ready = 1'b0;
    bus.win_done  = 1'b0;
    bus.rsp_ready = 1'b0;
    done_dly = 3; cmd_low = 0; rsp_low = 0; oneshot = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic set_job(input int r, input int s, input int e);
    bus.req_start[6*r +: 6] = 6'(s);
    bus.req_end[6*r +: 6]   = 6'(e);
  endtask

  // Plays requesters, slice_unit and response sink; samples at negedge, drives at posedge+1
  task automatic run_engine(input int target, input int budget);
    int done_cnt, cmd_wait, rsp_wait, g;
    bit pv, prv;
    logic [5:0] ps, pe;
    logic pl, perr;
    logic [ID_W-1:0] pid;
    logic [2:0] pwin;
    done_cnt = -1; cmd_wait = 0; rsp_wait = 0; pv = 0; prv = 0;
    ps = '0; pe = '0; pl = 0; perr = 0; pid = '0; pwin = '0;
    grant_id_q.delete(); grant_cyc_q.delete();
    cmd_s_q.delete(); cmd_e_q.delete(); cmd_l_q.delete(); cmd_cyc_q.delete();
    rsp_id_q.delete(); rsp_err_q.delete(); rsp_win_q.delete(); rsp_cyc_q.delete();
    cmd_valid_cyc = 0; cmd_unstable = 0; rsp_valid_cyc = 0; rsp_unstable = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      g = -1;
      for (int r = 0; r < NUM_REQ; r++) if (bus.req_ready[r]) g = r;
      if (g >= 0) begin grant_id_q.push_back(g); grant_cyc_q.push_back(c); end
      if (bus.cmd_valid) begin
        cmd_valid_cyc++;
        if (pv && (bus.cmd_start_idx !== ps || bus.cmd_end_idx !== pe || bus.cmd_last !== pl))
          cmd_unstable++;
        pv = 1; ps = bus.cmd_start_idx; pe = bus.cmd_end_idx; pl = bus.cmd_last;
        if (bus.cmd_ready) begin
          cmd_s_q.push_back(ps); cmd_e_q.push_back(pe); cmd_l_q.push_back(pl);
          cmd_cyc_q.push_back(c);
          done_cnt = done_dly;
          pv = 0;
        end else cmd_wait++;
      end else pv = 0;
      if (bus.rsp_valid) begin
        rsp_valid_cyc++;
        if (prv && (bus.rsp_id !== pid || bus.rsp_err !== perr || bus.rsp_windows !== pwin))
          rsp_unstable++;
        prv = 1; pid = bus.rsp_id; perr = bus.rsp_err; pwin = bus.rsp_windows;
        if (bus.rsp_ready) begin
          rsp_id_q.push_back(int'(pid)); rsp_err_q.push_back(int'(perr));
          rsp_win_q.push_back(int'(pwin)); rsp_cyc_q.push_back(c);
          prv = 0;
        end else rsp_wait++;
      end else prv = 0;
      if (rsp_id_q.size() >= target) break;
      @(posedge clk);
      #1;
      bus.win_done = 1'b0;
      if (done_cnt > 0) begin
        done_cnt--;
        if (done_cnt == 0) begin bus.win_done = 1'b1; done_cnt = -1; end
      end
      bus.cmd_ready = (cmd_wait >= cmd_low);
      bus.rsp_ready = (rsp_wait >= rsp_low);
      if (oneshot && g >= 0) bus.req_valid[g] = 1'b0;
    end
  endtask

  task automatic test_reset();
    do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({busy, bus.req_ready, bus.cmd_valid, bus.cmd_start_idx, bus.cmd_end_idx, bus.cmd_last,
         bus.rsp_valid, bus.rsp_id, bus.rsp_err, bus.rsp_windows} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: busy=%b req_ready=%b cmd_valid=%b rsp_valid=%b, all required 0",
               busy, bus.req_ready, bus.cmd_valid, bus.rsp_valid);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++; $display("FAIL idle_busy: got %b required 0", busy);
    end
  endtask

  task automatic test_full_job();
    int exp_s[4] = '{0, 16, 32, 48};
    int exp_e[4] = '{15, 31, 47, 63};
    do_reset();
    set_job(0, 0, 63);
    bus.req_valid = 4'b0001; bus.cmd_ready = 1'b1; bus.rsp_ready = 1'b1;
    run_engine(1, 200);
    tests_run++;
    if (cmd_s_q.size() !== 4) begin
      tests_failed++; $display("FAIL full_cmd_count: got %0d required 4", cmd_s_q.size());
    end
    for (int k = 0; k < 4; k++) begin
      tests_run++;
      if (k >= cmd_s_q.size() || grant_cyc_q.size() < 1) begin
        tests_failed++; $display("FAIL full_cmd%0d: missing, required %0d/%0d", k, exp_s[k], exp_e[k]);
      end else if (int'(cmd_s_q[k]) !== exp_s[k] || int'(cmd_e_q[k]) !== exp_e[k] ||
                   cmd_l_q[k] !== (k == 3) || cmd_cyc_q[k] - grant_cyc_q[0] !== 2 + 4*k) begin
        tests_failed++;
        $display("FAIL full_cmd%0d: got %0d/%0d last=%b at +%0d, required %0d/%0d last=%0d at +%0d",
                 k, cmd_s_q[k], cmd_e_q[k], cmd_l_q[k], cmd_cyc_q[k] - grant_cyc_q[0],
                 exp_s[k], exp_e[k], (k == 3), 2 + 4*k);
      end
    end
    tests_run++;
    if (rsp_id_q.size() < 1 || grant_cyc_q.size() < 1) begin
      tests_failed++; $display("FAIL full_rsp: no response, required id=0 err=0 windows=4");
    end else if (rsp_id_q[0] !== 0 || rsp_err_q[0] !== 0 || rsp_win_q[0] !== 4 ||
                 rsp_cyc_q[0] - grant_cyc_q[0] !== 18) begin
      tests_failed++;
      $display("FAIL full_rsp: got id=%0d err=%0d windows=%0d at +%0d, required 0/0/4 at +18",
               rsp_id_q[0], rsp_err_q[0], rsp_win_q[0], rsp_cyc_q[0] - grant_cyc_q[0]);
    end
  endtask

  task automatic test_round_robin();
    int exp_g[5] = '{0, 1, 2, 3, 0};
    do_reset();
    for (int r = 0; r < NUM_REQ; r++) set_job(r, 5, 5);
    bus.req_valid = 4'b1111; bus.cmd_ready = 1'b1; bus.rsp_ready = 1'b1;
    oneshot = 1'b0;
    run_engine(5, 400);
    bus.req_valid = '0;
    for (int k = 0; k < 5; k++) begin
      tests_run++;
      if (k >= rsp_id_q.size() || k >= grant_id_q.size() || k >= cmd_s_q.size()) begin
        tests_failed++; $display("FAIL rr_job%0d: missing, required grant %0d", k, exp_g[k]);
      end else if (grant_id_q[k] !== exp_g[k] || rsp_id_q[k] !== exp_g[k] || rsp_err_q[k] !== 0 ||
                   rsp_win_q[k] !== 1 || cmd_s_q[k] !== 6'd5 || cmd_e_q[k] !== 6'd5 ||
                   cmd_l_q[k] !== 1'b1) begin
        tests_failed++;
        $display("FAIL rr_job%0d: got grant=%0d rsp id=%0d err=%0d win=%0d cmd %0d/%0d last=%b, required grant=%0d id=%0d 0/1 cmd 5/5 last=1",
                 k, grant_id_q[k], rsp_id_q[k], rsp_err_q[k], rsp_win_q[k], cmd_s_q[k], cmd_e_q[k],
                 cmd_l_q[k], exp_g[k], exp_g[k]);
      end
    end
  endtask

  task automatic test_reject();
    do_reset();
    set_job(2, 40, 10);
    bus.req_valid = 4'b0100; bus.cmd_ready = 1'b1; bus.rsp_ready = 1'b1;
    run_engine(1, 50);
    tests_run++;
    if (cmd_valid_cyc !== 0) begin
      tests_failed++; $display("FAIL reject_no_cmd: got %0d cmd_valid cycles, required 0", cmd_valid_cyc);
    end
    tests_run++;
    if (rsp_id_q.size() < 1 || grant_cyc_q.size() < 1) begin
      tests_failed++; $display("FAIL reject_rsp: no response, required id=2 err=1 windows=0");
    end else if (rsp_id_q[0] !== 2 || rsp_err_q[0] !== 1 || rsp_win_q[0] !== 0 ||
                 rsp_cyc_q[0] - grant_cyc_q[0] !== 2) begin
      tests_failed++;
      $display("FAIL reject_rsp: got id=%0d err=%0d windows=%0d at +%0d, required 2/1/0 at +2",
               rsp_id_q[0], rsp_err_q[0], rsp_win_q[0], rsp_cyc_q[0] - grant_cyc_q[0]);
    end
  endtask

  task automatic test_cmd_stall();
    do_reset();
    set_job(1, 50, 63);
    bus.req_valid = 4'b0010; bus.cmd_ready = 1'b0; bus.rsp_ready = 1'b1;
    cmd_low = 5;
    run_engine(1, 100);
    tests_run++;
    if (cmd_valid_cyc !== 6 || cmd_unstable !== 0) begin
      tests_failed++;
      $display("FAIL stall_hold: got %0d valid cycles %0d changes, required 6 and 0", cmd_valid_cyc, cmd_unstable);
    end
    tests_run++;
    if (cmd_s_q.size() !== 1 || rsp_win_q.size() !== 1) begin
      tests_failed++; $display("FAIL stall_cmd: got %0d cmds %0d rsps, required 1 and 1", cmd_s_q.size(), rsp_win_q.size());
    end else if (cmd_s_q[0] !== 6'd50 || cmd_e_q[0] !== 6'd63 || cmd_l_q[0] !== 1'b1 ||
                 rsp_win_q[0] !== 1 || rsp_id_q[0] !== 1 || rsp_err_q[0] !== 0) begin
      tests_failed++;
      $display("FAIL stall_cmd: got cmd %0d/%0d last=%b rsp id=%0d err=%0d win=%0d, required 50/63 last=1 1/0/1",
               cmd_s_q[0], cmd_e_q[0], cmd_l_q[0], rsp_id_q[0], rsp_err_q[0], rsp_win_q[0]);
    end
  endtask

  task automatic test_rsp_backpressure();
    do_reset();
    set_job(0, 7, 20);
    set_job(3, 60, 63);
    bus.req_valid = 4'b1001; bus.cmd_ready = 1'b1; bus.rsp_ready = 1'b0;
    rsp_low = 4;
    run_engine(2, 200);
    tests_run++;
    if (rsp_valid_cyc !== 6 || rsp_unstable !== 0) begin
      tests_failed++;
      $display("FAIL rsp_hold: got %0d valid cycles %0d changes, required 6 and 0", rsp_valid_cyc, rsp_unstable);
    end
    tests_run++;
    if (rsp_id_q.size() !== 2 || grant_id_q.size() !== 2 || cmd_s_q.size() !== 2) begin
      tests_failed++;
      $display("FAIL rsp_order: got %0d rsps %0d grants %0d cmds, required 2 each",
               rsp_id_q.size(), grant_id_q.size(), cmd_s_q.size());
    end else if (rsp_id_q[0] !== 0 || rsp_id_q[1] !== 3 || rsp_win_q[0] !== 1 || rsp_win_q[1] !== 1 ||
                 cmd_s_q[0] !== 6'd7 || cmd_e_q[0] !== 6'd20 ||
                 cmd_s_q[1] !== 6'd60 || cmd_e_q[1] !== 6'd63 ||
                 grant_cyc_q[1] !== rsp_cyc_q[0] + 2) begin
      tests_failed++;
      $display("FAIL rsp_order: got ids %0d,%0d wins %0d,%0d cmds %0d/%0d %0d/%0d grant2 at %0d rsp1 at %0d, required 0,3 1,1 7/20 60/63 rsp1+2",
               rsp_id_q[0], rsp_id_q[1], rsp_win_q[0], rsp_win_q[1], cmd_s_q[0], cmd_e_q[0],
               cmd_s_q[1], cmd_e_q[1], grant_cyc_q[1], rsp_cyc_q[0]);
    end
  endtask

  task automatic test_reset_mid_job();
    do_reset();
    set_job(0, 0, 63);
    bus.req_valid = 4'b0001; bus.cmd_ready = 1'b1; bus.rsp_ready = 1'b1;
    done_dly = 0;
    run_engine(1, 8);
    tests_run++;
    if (cmd_s_q.size() !== 1 || busy !== 1'b1 || bus.cmd_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL midjob_wait: got %0d cmds busy=%b cmd_valid=%b, required 1 1 0", cmd_s_q.size(), busy, bus.cmd_valid);
    end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({busy, bus.req_ready, bus.cmd_valid, bus.cmd_start_idx, bus.cmd_end_idx, bus.cmd_last,
         bus.rsp_valid, bus.rsp_id, bus.rsp_err, bus.rsp_windows} !== '0) begin
      tests_failed++;
      $display("FAIL midjob_async_reset: busy=%b cmd_valid=%b rsp_valid=%b, all required 0",
               busy, bus.cmd_valid, bus.rsp_valid);
    end
    set_job(0, 5, 5);
    set_job(1, 9, 9);
    bus.req_valid = 4'b0011;
    done_dly = 3;
    @(posedge clk); #1 rst_n = 1'b1;
    run_engine(1, 100);
    tests_run++;
    if (grant_id_q.size() < 1 || rsp_id_q.size() < 1 || cmd_s_q.size() < 1) begin
      tests_failed++; $display("FAIL midjob_rr_reset: no job completed, required grant 0");
    end else if (grant_id_q[0] !== 0 || rsp_id_q[0] !== 0 || rsp_win_q[0] !== 1 ||
                 rsp_err_q[0] !== 0 || cmd_s_q[0] !== 6'd5) begin
      tests_failed++;
      $display("FAIL midjob_rr_reset: got grant=%0d id=%0d win=%0d err=%0d cmd_start=%0d, required 0/0/1/0/5",
               grant_id_q[0], rsp_id_q[0], rsp_win_q[0], rsp_err_q[0], cmd_s_q[0]);
    end
    bus.req_valid = '0;
  endtask

`ifdef SLICE_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    set_job(0, 0, 63);
    bus.req_valid = 4'b0001; bus.cmd_ready = 1'b1; bus.rsp_ready = 1'b1;
    done_dly = 0;
    run_engine(1, 600);
    tests_run++;
    if (rsp_id_q.size() < 1 || cmd_cyc_q.size() < 1) begin
      tests_failed++; $display("FAIL timeout_rsp: no response, required err=1 windows=1");
    end else if (rsp_err_q[0] !== 1 || rsp_win_q[0] !== 1 || rsp_id_q[0] !== 0 ||
                 rsp_cyc_q[0] - cmd_cyc_q[0] !== 256) begin
      tests_failed++;
      $display("FAIL timeout_rsp: got id=%0d err=%0d win=%0d at +%0d, required 0/1/1 at +256",
               rsp_id_q[0], rsp_err_q[0], rsp_win_q[0], rsp_cyc_q[0] - cmd_cyc_q[0]);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_full_job();
    test_round_robin();
    test_reject();
    test_cmd_stall();
    test_rsp_backpressure();
    test_reset_mid_job();
`ifdef SLICE_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
